// File: rtl/rx_cmd_sequencer_pkg.sv
// Shared UART package: data/opcode width defaults and the command
// sequencer state encoding, reused by the receiver and transmitter side.
package rx_cmd_sequencer_pkg;

  localparam int unsigned DBIT_DEF          = 8;
  localparam int unsigned OPW_DEF           = 6;
  localparam int unsigned TIMEOUT_TICKS_DEF = 640;

  typedef enum logic [2:0] {
    WAIT_A  = 3'd0,
    WAIT_B  = 3'd1,
    WAIT_OP = 3'd2,
    EXEC    = 3'd3,
    SEND    = 3'd4,
    WAIT_TX = 3'd5
  } seq_state_t;

  // States in which an incoming byte is part of the command being assembled.
  function automatic logic is_rx_state(input seq_state_t s);
    return (s == WAIT_A) || (s == WAIT_B) || (s == WAIT_OP);
  endfunction

endpackage

// File: rtl/rx_timeout_counter.sv
// Inter-byte timeout counter. Counts s_tick while enabled, saturates at
// TIMEOUT_TICKS and flags expiry; clear has priority over counting.
// Ports: clk, reset (async, active-high), clear, enable, s_tick -> expired.
module rx_timeout_counter #(
  parameter int unsigned TIMEOUT_TICKS = 640
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  input  logic s_tick,
  output logic expired
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_TICKS);

  logic [CNT_W-1:0] count;

  // Saturating count; expired is registered alongside the count so it is
  // high exactly while count == LIMIT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count   <= '0;
      expired <= 1'b0;
    end else if (clear) begin
      count   <= '0;
      expired <= 1'b0;
    end else if (enable && s_tick && (count != LIMIT)) begin
      count   <= count + CNT_W'(1);
      expired <= (count == (LIMIT - CNT_W'(1)));
    end
  end

endmodule

// File: rtl/rx_cmd_sequencer.sv
// UART command sequencer: assembles operand A, operand B and an opcode from
// received bytes, samples the external ALU, and hands the result to the
// transmitter. Flags bytes arriving while busy (overrun) and stalled commands
// (timeout between bytes).
// Ports: clk, reset (async, active-high), s_tick, rx_done_tick, rx_data,
//        alu_result, tx_done_tick -> op_a, op_b, opcode, tx_start, tx_data,
//        busy, overrun_err, timeout_err.
module rx_cmd_sequencer
  import rx_cmd_sequencer_pkg::*;
#(
  parameter int unsigned DBIT          = DBIT_DEF,
  parameter int unsigned OPW           = OPW_DEF,
  parameter int unsigned TIMEOUT_TICKS = TIMEOUT_TICKS_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            s_tick,
  input  logic            rx_done_tick,
  input  logic [DBIT-1:0] rx_data,
  input  logic [DBIT-1:0] alu_result,
  input  logic            tx_done_tick,
  output logic [DBIT-1:0] op_a,
  output logic [DBIT-1:0] op_b,
  output logic [OPW-1:0]  opcode,
  output logic            tx_start,
  output logic [DBIT-1:0] tx_data,
  output logic            busy,
  output logic            overrun_err,
  output logic            timeout_err
);

  seq_state_t state;
  logic       expired;
  logic       clear_c;
  logic       enable_c;

  // Every accepted byte restarts the inter-byte timer; it only runs while
  // waiting for the second or third byte of a command.
  assign clear_c  = rx_done_tick && is_rx_state(state);
  assign enable_c = (state == WAIT_B) || (state == WAIT_OP);

  rx_timeout_counter #(
    .TIMEOUT_TICKS(TIMEOUT_TICKS)
  ) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .clear  (clear_c),
    .enable (enable_c),
    .s_tick (s_tick),
    .expired(expired)
  );

  // Command FSM with registered outputs; a byte arriving together with
  // expiry wins over the timeout.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= WAIT_A;
      op_a        <= '0;
      op_b        <= '0;
      opcode      <= '0;
      tx_data     <= '0;
      tx_start    <= 1'b0;
      busy        <= 1'b0;
      overrun_err <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      tx_start    <= 1'b0;
      overrun_err <= 1'b0;
      timeout_err <= 1'b0;
      case (state)
        WAIT_A: begin
          if (rx_done_tick) begin
            op_a  <= rx_data;
            busy  <= 1'b1;
            state <= WAIT_B;
          end
        end
        WAIT_B: begin
          if (rx_done_tick) begin
            op_b  <= rx_data;
            state <= WAIT_OP;
          end else if (expired) begin
            timeout_err <= 1'b1;
            busy        <= 1'b0;
            state       <= WAIT_A;
          end
        end
        WAIT_OP: begin
          if (rx_done_tick) begin
            opcode <= rx_data[OPW-1:0];
            state  <= EXEC;
          end else if (expired) begin
            timeout_err <= 1'b1;
            busy        <= 1'b0;
            state       <= WAIT_A;
          end
        end
        EXEC: begin
          // tx_start is high for the whole SEND cycle.
          tx_data  <= alu_result;
          tx_start <= 1'b1;
          state    <= SEND;
        end
        SEND: begin
          state <= WAIT_TX;
        end
        WAIT_TX: begin
          if (tx_done_tick) begin
            busy  <= 1'b0;
            state <= WAIT_A;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= WAIT_A;
        end
      endcase
      if (rx_done_tick && !is_rx_state(state)) begin
        overrun_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rx_cmd_sequencer.sv
// Scoreboard bench for rx_cmd_sequencer: stimulus pushes expected results
// (data and cycle of arrival), a negedge monitor pops and compares.
module tb_rx_cmd_sequencer;

  logic       clk;
  logic       reset;
  logic       s_tick;
  logic       rx_done_tick;
  logic [7:0] rx_data;
  logic [7:0] alu_result;
  logic       tx_done_tick;
  logic [7:0] op_a;
  logic [7:0] op_b;
  logic [5:0] opcode;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       busy;
  logic       overrun_err;
  logic       timeout_err;

  rx_cmd_sequencer #(
    .DBIT(8),
    .OPW(6),
    .TIMEOUT_TICKS(640)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .s_tick      (s_tick),
    .rx_done_tick(rx_done_tick),
    .rx_data     (rx_data),
    .alu_result  (alu_result),
    .tx_done_tick(tx_done_tick),
    .op_a        (op_a),
    .op_b        (op_b),
    .opcode      (opcode),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .busy        (busy),
    .overrun_err (overrun_err),
    .timeout_err (timeout_err)
  );

  typedef struct {
    logic [7:0] data;
    int         cyc;
  } exp_t;

  exp_t tx_q[$];
  int   ov_q[$];
  int   to_q[$];

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   tx_seen = 0;
  int   seen_base = 0;
  bit   rand_ticks = 0;

  logic       hold_active;
  logic [7:0] held;
  logic       prev_tx_start, prev_ov, prev_to;
  exp_t       mon_e;
  int         mon_c;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference ALU used both as the environment's ALU and by the model.
  function automatic logic [7:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                        input logic [5:0] op);
    case (op)
      6'h20:   return a + b;
      6'h22:   return a - b;
      6'h24:   return a & b;
      6'h25:   return a | b;
      6'h26:   return a ^ b;
      6'h27:   return ~(a | b);
      default: return a;
    endcase
  endfunction

  always_comb alu_result = alu_fn(op_a, op_b, opcode);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every DUT output event is matched against the scoreboard.
  always @(negedge clk) begin
    if (reset) begin
      hold_active   = 1'b0;
      prev_tx_start = 1'b0;
      prev_ov       = 1'b0;
      prev_to       = 1'b0;
    end else begin
      if (tx_start) begin
        check("tx_start_width", 32'(prev_tx_start), 32'd0);
        if (tx_q.size() == 0) begin
          check("tx_start_unexpected", 32'd1, 32'd0);
        end else begin
          mon_e = tx_q.pop_front();
          check("tx_data", 32'(tx_data), 32'(mon_e.data));
          check("tx_latency", 32'(cyc), 32'(mon_e.cyc));
        end
        held        = tx_data;
        hold_active = 1'b1;
        tx_seen++;
      end else if (hold_active) begin
        check("tx_data_hold", 32'(tx_data), 32'(held));
        if (tx_done_tick) hold_active = 1'b0;
      end
      if (overrun_err) begin
        check("overrun_width", 32'(prev_ov), 32'd0);
        if (ov_q.size() == 0) begin
          check("overrun_unexpected", 32'd1, 32'd0);
        end else begin
          mon_c = ov_q.pop_front();
          check("overrun_cycle", 32'(cyc), 32'(mon_c));
        end
      end
      if (timeout_err) begin
        check("timeout_width", 32'(prev_to), 32'd0);
        if (to_q.size() == 0) begin
          check("timeout_unexpected", 32'd1, 32'd0);
        end else begin
          mon_c = to_q.pop_front();
          check("timeout_cycle", 32'(cyc), 32'(mon_c));
        end
      end
      prev_tx_start = tx_start;
      prev_ov       = overrun_err;
      prev_to       = timeout_err;
    end
  end

  function automatic logic rnd_tick();
    return rand_ticks && ($urandom_range(0, 15) == 0);
  endfunction

  // One clock of stimulus, driven just after the rising edge.
  task automatic step(input logic rx, input logic [7:0] d, input logic st, input logic td);
    @(posedge clk);
    #1;
    rx_done_tick = rx;
    rx_data      = d;
    s_tick       = st;
    tx_done_tick = td;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, rnd_tick(), 1'b0);
  endtask

  task automatic send_byte(input logic [7:0] b);
    step(1'b1, b, rnd_tick(), 1'b0);
  endtask

  // n consecutive s_ticks; optionally predicts the timeout pulse two clocks
  // after the last tick (counter reaches the limit, FSM reacts next clock).
  task automatic ticks(input int n, input bit expect_to);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    if (expect_to) to_q.push_back(cyc + 2);
  endtask

  // Call right after the opcode byte was driven.
  task automatic expect_tx(input logic [7:0] a, input logic [7:0] b, input logic [7:0] opb);
    exp_t e;
    e.data = alu_fn(a, b, opb[5:0]);
    e.cyc  = cyc + 2;
    tx_q.push_back(e);
    seen_base = tx_seen;
  endtask

  task automatic wait_tx();
    bit got;
    got = 1'b0;
    for (int k = 0; k < 8 && !got; k++) begin
      idle(1);
      @(negedge clk);
      #1;
      if (tx_seen != seen_base) got = 1'b1;
    end
    check("tx_start_wait", 32'(got), 32'd1);
  endtask

  task automatic finish_tx(input int txlat, input bit ov);
    wait_tx();
    for (int k = 0; k < txlat; k++) begin
      if (ov && (k == txlat / 2)) begin
        send_byte(8'hAA);
        ov_q.push_back(cyc + 1);
      end else begin
        idle(1);
      end
    end
    idle(1);
    @(negedge clk);
    check("busy_before_tx_done", 32'(busy), 32'd1);
    step(1'b0, 8'h00, rnd_tick(), 1'b1);
    idle(1);
    @(negedge clk);
    check("busy_after_tx_done", 32'(busy), 32'd0);
  endtask

  task automatic run_cmd(input logic [7:0] a, input logic [7:0] b, input logic [7:0] opb,
                         input int gap, input int txlat, input bit ov);
    send_byte(a);
    idle(gap);
    send_byte(b);
    idle(gap);
    send_byte(opb);
    expect_tx(a, b, opb);
    finish_tx(txlat, ov);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_op_a"}, 32'(op_a), 32'd0);
    check({tag, "_op_b"}, 32'(op_b), 32'd0);
    check({tag, "_opcode"}, 32'(opcode), 32'd0);
    check({tag, "_tx_data"}, 32'(tx_data), 32'd0);
    check({tag, "_tx_start"}, 32'(tx_start), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_overrun"}, 32'(overrun_err), 32'd0);
    check({tag, "_timeout"}, 32'(timeout_err), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] a, b, opb;
    logic [5:0] ops [6];
    ops = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27};
    reset = 1'b1;
    s_tick = 1'b0;
    rx_done_tick = 1'b0;
    rx_data = 8'h00;
    tx_done_tick = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("in_reset");
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check_all_zero("after_reset");

    // Basic add and 8-bit truncation.
    run_cmd(8'h05, 8'h03, 8'h20, 1, 3, 1'b0);
    run_cmd(8'hFF, 8'hFF, 8'hE0, 0, 2, 1'b0);

    // Extra byte while waiting for the transmitter, then a clean command.
    run_cmd(8'h12, 8'h34, 8'h22, 0, 6, 1'b1);
    run_cmd(8'h07, 8'h09, 8'h20, 0, 2, 1'b0);

    // Silence after the first byte times out; the next bytes start fresh.
    send_byte(8'h05);
    ticks(640, 1'b1);
    idle(4);
    @(negedge clk);
    check("busy_after_timeout", 32'(busy), 32'd0);
    check("op_a_retained", 32'(op_a), 32'h05);
    run_cmd(8'h21, 8'h10, 8'h22, 0, 2, 1'b0);

    // Timeout while waiting for the opcode.
    send_byte(8'h01);
    send_byte(8'h02);
    ticks(640, 1'b1);
    idle(3);
    run_cmd(8'h0F, 8'hF0, 8'h25, 1, 1, 1'b0);

    // Opcode byte on the 640th tick: accepted, no timeout.
    send_byte(8'h31);
    idle(2);
    send_byte(8'h12);
    ticks(639, 1'b0);
    step(1'b1, 8'h20, 1'b1, 1'b0);
    expect_tx(8'h31, 8'h12, 8'h20);
    finish_tx(2, 1'b0);

    // Byte arriving in the same clock the timeout has expired: accepted.
    send_byte(8'h44);
    ticks(640, 1'b0);
    send_byte(8'h11);
    send_byte(8'h26);
    expect_tx(8'h44, 8'h11, 8'h26);
    finish_tx(2, 1'b0);

    // Asynchronous reset while waiting for the transmitter.
    send_byte(8'h5A);
    send_byte(8'h0C);
    send_byte(8'h24);
    expect_tx(8'h5A, 8'h0C, 8'h24);
    wait_tx();
    idle(1);
    #3;
    reset = 1'b1;
    #1;
    check_all_zero("async_reset");
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle(1);
    run_cmd(8'h0A, 8'h0B, 8'h20, 0, 2, 1'b0);

    // Randomized commands with background ticks and occasional overruns.
    rand_ticks = 1'b1;
    for (int i = 0; i < 25; i++) begin
      a   = 8'($urandom_range(0, 255));
      b   = 8'($urandom_range(0, 255));
      opb = {2'($urandom_range(0, 3)), ops[$urandom_range(0, 5)]};
      if ($urandom_range(0, 7) == 0) opb = 8'($urandom_range(0, 255));
      run_cmd(a, b, opb, $urandom_range(0, 3), $urandom_range(1, 8),
              ($urandom_range(0, 3) == 0));
    end
    rand_ticks = 1'b0;
    idle(4);

    check("tx_queue_empty", 32'(tx_q.size()), 32'd0);
    check("overrun_queue_empty", 32'(ov_q.size()), 32'd0);
    check("timeout_queue_empty", 32'(to_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rx_cmd_sequencer.md
RX_CMD_SEQUENCER -- requirements
Module: rx_cmd_sequencer

Interface
REQ-001 SHALL have parameter DBIT, default 8, data byte width.
REQ-002 SHALL have parameter OPW, default 6, opcode width; opcode = low OPW bits of third byte.
REQ-003 SHALL have parameter TIMEOUT_TICKS, default 640, s_tick count allowed between bytes of one command.
REQ-004 SHALL have port clk  input  1  single system clock; all state on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port s_tick  input  1  baud oversample tick (16x), one clk wide.
REQ-007 SHALL have port rx_done_tick  input  1  receiver byte-valid strobe, one clk wide.
REQ-008 SHALL have port rx_data  input  DBIT  received byte, valid with rx_done_tick.
REQ-009 SHALL have port alu_result  input  DBIT  combinational ALU output from op_a/op_b/opcode.
REQ-010 SHALL have port tx_done_tick  input  1  transmitter byte-complete strobe.
REQ-011 SHALL have port op_a, op_b  output  DBIT each  registered operands.
REQ-012 SHALL have port opcode  output  OPW  registered opcode.
REQ-013 SHALL have port tx_start  output  1  one-clk request to transmitter.
REQ-014 SHALL have port tx_data  output  DBIT  result byte, held stable from tx_start until tx_done_tick.
REQ-015 SHALL have port busy  output  1  high in every state except WAIT_A.
REQ-016 SHALL have port overrun_err, timeout_err  output  1 each  one-clk error pulses.

Function
REQ-017 SHALL implement states WAIT_A, WAIT_B, WAIT_OP, EXEC, SEND, WAIT_TX.
REQ-018 WAIT_A: on rx_done_tick, op_a <= rx_data, go WAIT_B.
REQ-019 WAIT_B: on rx_done_tick, op_b <= rx_data, go WAIT_OP.
REQ-020 WAIT_OP: on rx_done_tick, opcode <= rx_data[OPW-1:0], go EXEC.
REQ-021 EXEC: lasts exactly one clk; tx_data <= alu_result; go SEND.
REQ-022 SEND: tx_start = 1 for exactly one clk; go WAIT_TX.
REQ-023 WAIT_TX: on tx_done_tick go WAIT_A; tx_done_tick in any other state ignored.
REQ-024 Latency: tx_start asserted exactly 2 clk after the clk in which the opcode byte's rx_done_tick is sampled.
REQ-025 Timeout counter: cleared on entry to WAIT_B/WAIT_OP and on each accepted byte; increments on s_tick in WAIT_B/WAIT_OP only.
REQ-026 When counter reaches TIMEOUT_TICKS in WAIT_B/WAIT_OP: timeout_err pulses one clk, go WAIT_A; op_a/op_b/opcode retain values.
REQ-027 rx_done_tick and timeout expiry in same clk: byte accepted, no timeout_err.
REQ-028 rx_done_tick in EXEC, SEND or WAIT_TX: byte dropped, overrun_err pulses one clk, state unaffected.
REQ-029 Counter width SHALL be $clog2(TIMEOUT_TICKS+1); no wrap-around before expiry.
REQ-030 alu_result sampled only in EXEC; changes elsewhere ignored.

Reset
REQ-031 reset SHALL force state WAIT_A asynchronously, from any state including mid-command or mid-transmit.
REQ-032 Reset values: op_a=0, op_b=0, opcode=0, tx_data=0, tx_start=0, busy=0, overrun_err=0, timeout_err=0, counter=0.
REQ-033 First rx_done_tick after reset release SHALL be treated as op_a.

Structure
REQ-034 State encoding constants, DBIT and OPW defaults SHALL live in the shared uart package, reused by receiver/transmitter.
REQ-035 Timeout counter SHALL be sub-module rx_timeout_counter (inputs clk, reset, clear, enable, s_tick; output expired).
REQ-036 Remaining logic SHALL be a single registered FSM with registered outputs.

Verification
REQ-037 Bytes 0x05, 0x03, 0x20 with alu=add -> tx_start 2 clk after third byte, tx_data=0x08; tx_done_tick -> busy=0.
REQ-038 0x05 then 640 s_ticks silence -> timeout_err one pulse, state WAIT_A; next 3 bytes form a fresh command.
REQ-039 Extra byte 0xAA during WAIT_TX -> overrun_err one pulse, tx_data unchanged, next command correct.
REQ-040 Opcode byte rx_done_tick coincident with 640th s_tick -> EXEC entered, no timeout_err.
REQ-041 reset asserted in WAIT_TX -> all outputs 0 immediately; subsequent 3-byte command completes normally.
REQ-042 0xFF, 0xFF, 0xE0 (opcode 0x20) -> tx_data = 0xFE (8-bit truncated sum), tx_start single clk wide.
